// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the round-robin UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer and transmitter signals of the scheduler, bundled for port connection.
// Handshakes: a producer holds req[i]/byte until ack[i] pulses for one cycle;
// tx_send stays high with a stable tx_data until the transmitter raises tx_done.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_done;

  modport master (
    input  req, req_data, tx_done,
    output ack, tx_send, tx_data
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, tx_send, tx_data
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so last+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     winner,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [IDW-1:0]     offset;
  logic               found;

  always_comb begin
    rot    = '0;
    offset = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[(int'(last) + 1 + i) % NUM_REQ];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        offset = IDW'(i);
      end
    end
    winner = IDW'((int'(last) + 1 + int'(offset)) % NUM_REQ);
    any    = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin grant,
// byte latch, tx_done edge detection, frame watchdog and optional inter-frame gap.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_sched_if.master       bus,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  timeout_err,
  output sched_state_t          dbg_state
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  sched_state_t       state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [7:0]         data_q, data_d;
  logic               send_q, send_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               terr_q, terr_d;
  logic               busy_q, busy_d;
  logic               done_q;
  logic [WW-1:0]      wd_q, wd_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic [IDW-1:0]     arb_winner;
  logic               arb_any;
  logic               done_rise;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req),
    .last   (last_q),
    .winner (arb_winner),
    .any    (arb_any)
  );

  // A tx_done already high when SEND starts has done_q=1 and never counts.
  assign done_rise = bus.tx_done && !done_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    data_d  = data_q;
    send_d  = send_q;
    ack_d   = '0;
    terr_d  = 1'b0;
    wd_d    = wd_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = SEND;
          data_d  = bus.req_data[{arb_winner, 3'b000} +: 8];
          gid_d   = arb_winner;
          last_d  = arb_winner;
          send_d  = 1'b1;
          wd_d    = '0;
        end
      end
      SEND: begin
        if (done_rise) begin
          state_d       = DRAIN;
          send_d        = 1'b0;
          ack_d[gid_q]  = 1'b1;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DRAIN;
          send_d  = 1'b0;
          terr_d  = 1'b1;
        end else if (wd_q != WW'(TIMEOUT_CYCLES)) begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.tx_done) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NUM_REQ - 1);
      gid_q   <= '0;
      data_q  <= 8'h00;
      send_q  <= 1'b0;
      ack_q   <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      send_q  <= send_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      done_q  <= bus.tx_done;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.tx_send  = send_q;
  assign bus.tx_data  = data_q;
  assign bus.ack      = ack_q;
  assign busy         = busy_q;
  assign grant_id     = gid_q;
  assign timeout_err  = terr_q;
  assign dbg_state    = state_q;

endmodule
